ace_snoop_responder: RTL
========================

Name: ace_snoop_responder

Overview:
Cache-side endpoint of the ACE snoop channels. It accepts one AC snoop request at a time, looks up the line in the local dcache, and returns the CR response. When data must move, it streams the line on CD as DcacheLineWords beats. It also issues the required coherence-state update to the cache. One instance sits at each snooped master port, opposite the CCU snoop initiator.

Parameters:
DcacheLineWidth, 128, cache line width in bits.
AxiDataWidth, 64, CD beat width in bits; DcacheLineWords = DcacheLineWidth/AxiDataWidth (>=1, integer).
AxiAddrWidth, 64, AC address width.
snoop_req_t, logic, struct {ac_valid, ac{addr,prot,snoop}, cr_ready, cd_ready}.
snoop_resp_t, logic, struct {ac_ready, cr_valid, cr_resp{dataTransfer,error,passDirty,isShared,wasUnique}, cd_valid, cd{data,last}}.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
snoop_req_i  in  snoop_req_t  AC request plus CR/CD ready from the CCU
snoop_resp_o  out  snoop_resp_t  AC ready plus CR/CD response to the CCU
lookup_req_o  out  1  cache tag lookup request
lookup_addr_o  out  AxiAddrWidth  line-aligned snoop address
lookup_gnt_i  in  1  lookup accepted
lookup_valid_i  in  1  lookup result valid (one-cycle pulse, arrives after the grant)
lookup_hit_i / lookup_dirty_i / lookup_shared_i  in  1 each  line state
lookup_line_i  in  DcacheLineWidth  line data, valid with lookup_valid_i
upd_req_o  out  1  state update request
upd_op_o  out  2  update op: 0 NONE, 1 INVALIDATE, 2 MAKE_SHARED, 3 CLEAN
upd_addr_o  out  AxiAddrWidth  line-aligned address
upd_gnt_i  in  1  update accepted
busy_o  out  1  high when the FSM is not in IDLE

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All valid/req outputs are 0, busy_o=0, beat counter=0.
  - Captured AC, response and line registers are cleared.
  - Reset mid-transaction abandons the transaction with no further outputs.
- ac_ready = (state==IDLE).
  - AC handshake (ac_valid & ac_ready) latches addr/snoop/prot and moves to LOOKUP.
- LOOKUP:
  - lookup_req_o=1 with the aligned addr (low $clog2(DcacheLineWidth/8) bits zeroed).
  - On lookup_gnt_i, go to WAIT_LOOKUP.
- WAIT_LOOKUP:
  - On lookup_valid_i, latch hit/dirty/shared/line and compute the response (below).
  - Next state: UPDATE if op!=NONE, else SEND_CR.
- Response by snoop code, on a hit (isShared/passDirty/dataTransfer; update op):
  - READ_ONCE: dT=1, isShared=1, passDirty=0; NONE.
  - READ_SHARED: dT=1, isShared=1, passDirty=dirty; MAKE_SHARED.
  - READ_UNIQUE: dT=1, passDirty=dirty; INVALIDATE.
  - CLEAN_INVALID: dT=dirty, passDirty=dirty; INVALIDATE.
  - CLEAN_SHARED: dT=dirty, passDirty=dirty, isShared=1; CLEAN if dirty, else NONE.
  - MAKE_INVALID: dT=0; INVALIDATE.
  - Unlisted codes: error=1, all other bits 0; NONE.
- wasUnique = hit & !shared for every supported code.
- A miss yields an all-zero CR and NONE.
- UPDATE:
  - upd_req_o=1 with op and addr held stable until upd_gnt_i, then go to SEND_CR.
  - The update is always issued before the CR, so a later snoop never sees stale state.
- SEND_CR:
  - cr_valid=1, cr_resp held stable until cr_ready.
  - On handshake: go to SEND_CD if dataTransfer, else IDLE.
- SEND_CD:
  - cd_valid=1; beat k drives line[k*AxiDataWidth +: AxiDataWidth].
  - last=1 on beat DcacheLineWords-1.
  - The counter advances only on cd_valid & cd_ready.
  - The final beat handshake clears the counter and returns to IDLE.
  - Data is taken from the latched copy, so later cache changes do not affect it.
- Minimum latency: from AC handshake to cr_valid is 2 cycles plus cache latency (lookup_gnt in the LOOKUP cycle, valid the next cycle); UPDATE adds ≥1.
- A new AC request is not accepted until IDLE; back-to-back snoops incur one idle cycle for the AC handshake.
- DcacheLineWords==1: a single beat with last=1.
- lookup_valid_i outside WAIT_LOOKUP is ignored.
- Outputs in SEND_CR/SEND_CD are stable while the corresponding ready is low.

Test Plan:
- Miss: ac{addr=0x1008, READ_SHARED}, hit=0 -> lookup_addr_o=0x1000, no upd_req_o, CR=all 0, no cd_valid, back to IDLE, ac_ready=1.
- READ_UNIQUE dirty hit, line=0xAAAA..._5555...:
  - upd INVALIDATE issued first.
  - Then CR {dT=1, passDirty=1, wasUnique=1}.
  - CD beat0=0x5555..., beat1=0xAAAA... with last on beat1.
- CD backpressure: cd_ready low 3 cycles on beat0 -> data/valid/last stable, counter holds, exactly 2 beats transferred.
- CLEAN_SHARED clean shared hit -> no update, CR {isShared=1, wasUnique=0, dT=0}, no CD.
- CR backpressure plus upd_gnt delay of 4 cycles -> cr_valid rises only after grant; ac_ready stays 0 throughout.
- Unsupported snoop code -> CR error=1 only; reset asserted during SEND_CD -> all valids 0 immediately, IDLE after release.

Source files
------------

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: takes one AC snoop, looks the line up in the dcache,
// applies the coherence update, then answers on CR and streams data on CD.
package ace_snoop_pkg;
  localparam int unsigned AddrW = 64;
  localparam int unsigned DataW = 64;

  localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
  localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED  = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_INVALIDATE,
    UPD_MAKE_SHARED,
    UPD_CLEAN
  } upd_op_e;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [2:0]       prot;
    logic [3:0]       snoop;
  } ace_ac_t;

  typedef struct packed {
    logic    ac_valid;
    ace_ac_t ac;
    logic    cr_ready;
    logic    cd_ready;
  } snoop_req_t;

  typedef struct packed {
    logic dataTransfer;
    logic error;
    logic passDirty;
    logic isShared;
    logic wasUnique;
  } ace_cr_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic             last;
  } ace_cd_t;

  typedef struct packed {
    logic    ac_ready;
    logic    cr_valid;
    ace_cr_t cr_resp;
    logic    cd_valid;
    ace_cd_t cd;
  } snoop_resp_t;
endpackage

module ace_snoop_responder #(
  parameter int unsigned DcacheLineWidth = 128,
  parameter int unsigned AxiDataWidth    = 64,
  parameter int unsigned AxiAddrWidth    = 64,
  parameter type snoop_req_t  = ace_snoop_pkg::snoop_req_t,
  parameter type snoop_resp_t = ace_snoop_pkg::snoop_resp_t
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  snoop_req_t                 snoop_req_i,
  output snoop_resp_t                snoop_resp_o,
  output logic                       lookup_req_o,
  output logic [AxiAddrWidth-1:0]    lookup_addr_o,
  input  logic                       lookup_gnt_i,
  input  logic                       lookup_valid_i,
  input  logic                       lookup_hit_i,
  input  logic                       lookup_dirty_i,
  input  logic                       lookup_shared_i,
  input  logic [DcacheLineWidth-1:0] lookup_line_i,
  output logic                       upd_req_o,
  output logic [1:0]                 upd_op_o,
  output logic [AxiAddrWidth-1:0]    upd_addr_o,
  input  logic                       upd_gnt_i,
  output logic                       busy_o
);

  localparam int unsigned Words = DcacheLineWidth / AxiDataWidth;
  localparam int unsigned OffW  = $clog2(DcacheLineWidth / 8);
  localparam int unsigned BeatW = (Words > 1) ? $clog2(Words) : 1;
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Words - 1);
  localparam logic [AxiAddrWidth-1:0] AlignMask =
    {{(AxiAddrWidth-OffW){1'b1}}, {OffW{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_LOOKUP,
    UPDATE,
    SEND_CR,
    SEND_CD
  } state_e;

  state_e                       state_q, state_d;
  logic [AxiAddrWidth-1:0]      addr_q, addr_d;
  logic [3:0]                   snoop_q, snoop_d;
  logic [2:0]                   prot_q, prot_d;
  ace_snoop_pkg::ace_cr_t       cr_q, cr_d;
  ace_snoop_pkg::upd_op_e       op_q, op_d;
  logic [Words-1:0][AxiDataWidth-1:0] line_q, line_d;
  logic [BeatW-1:0]             cnt_q, cnt_d;

  ace_snoop_pkg::ace_cr_t       cr_l;
  ace_snoop_pkg::upd_op_e       op_l;
  logic                         supported;

  logic unused_prot;
  assign unused_prot = ^prot_q;

  // Response table, evaluated against the live lookup result.
  always_comb begin
    cr_l      = '0;
    op_l      = ace_snoop_pkg::UPD_NONE;
    supported = 1'b1;
    case (snoop_q)
      ace_snoop_pkg::SNP_READ_ONCE: begin
        cr_l.dataTransfer = 1'b1;
        cr_l.isShared     = 1'b1;
      end
      ace_snoop_pkg::SNP_READ_SHARED: begin
        cr_l.dataTransfer = 1'b1;
        cr_l.isShared     = 1'b1;
        cr_l.passDirty    = lookup_dirty_i;
        op_l              = ace_snoop_pkg::UPD_MAKE_SHARED;
      end
      ace_snoop_pkg::SNP_READ_UNIQUE: begin
        cr_l.dataTransfer = 1'b1;
        cr_l.passDirty    = lookup_dirty_i;
        op_l              = ace_snoop_pkg::UPD_INVALIDATE;
      end
      ace_snoop_pkg::SNP_CLEAN_INVALID: begin
        cr_l.dataTransfer = lookup_dirty_i;
        cr_l.passDirty    = lookup_dirty_i;
        op_l              = ace_snoop_pkg::UPD_INVALIDATE;
      end
      ace_snoop_pkg::SNP_CLEAN_SHARED: begin
        cr_l.dataTransfer = lookup_dirty_i;
        cr_l.passDirty    = lookup_dirty_i;
        cr_l.isShared     = 1'b1;
        if (lookup_dirty_i) op_l = ace_snoop_pkg::UPD_CLEAN;
      end
      ace_snoop_pkg::SNP_MAKE_INVALID: begin
        op_l = ace_snoop_pkg::UPD_INVALIDATE;
      end
      default: begin
        supported  = 1'b0;
        cr_l.error = 1'b1;
      end
    endcase
    if (supported) begin
      cr_l.wasUnique = lookup_hit_i & ~lookup_shared_i;
      if (!lookup_hit_i) begin
        cr_l = '0;
        op_l = ace_snoop_pkg::UPD_NONE;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    snoop_d = snoop_q;
    prot_d  = prot_q;
    cr_d    = cr_q;
    op_d    = op_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (snoop_req_i.ac_valid) begin
          addr_d  = snoop_req_i.ac.addr;
          snoop_d = snoop_req_i.ac.snoop;
          prot_d  = snoop_req_i.ac.prot;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (lookup_gnt_i) state_d = WAIT_LOOKUP;
      end
      WAIT_LOOKUP: begin
        if (lookup_valid_i) begin
          cr_d    = cr_l;
          op_d    = op_l;
          line_d  = lookup_line_i;
          state_d = (op_l != ace_snoop_pkg::UPD_NONE) ? UPDATE : SEND_CR;
        end
      end
      UPDATE: begin
        if (upd_gnt_i) state_d = SEND_CR;
      end
      SEND_CR: begin
        if (snoop_req_i.cr_ready)
          state_d = cr_q.dataTransfer ? SEND_CD : IDLE;
      end
      SEND_CD: begin
        if (snoop_req_i.cd_ready) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      snoop_q <= '0;
      prot_q  <= '0;
      cr_q    <= '0;
      op_q    <= ace_snoop_pkg::UPD_NONE;
      line_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      snoop_q <= snoop_d;
      prot_q  <= prot_d;
      cr_q    <= cr_d;
      op_q    <= op_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    snoop_resp_o          = '0;
    snoop_resp_o.ac_ready = (state_q == IDLE);
    snoop_resp_o.cr_valid = (state_q == SEND_CR);
    snoop_resp_o.cr_resp  = cr_q;
    snoop_resp_o.cd_valid = (state_q == SEND_CD);
    snoop_resp_o.cd.data  = line_q[cnt_q];
    snoop_resp_o.cd.last  = (cnt_q == LastBeat);
  end

  assign lookup_req_o  = (state_q == LOOKUP);
  assign lookup_addr_o = addr_q & AlignMask;
  assign upd_req_o     = (state_q == UPDATE);
  assign upd_op_o      = op_q;
  assign upd_addr_o    = addr_q & AlignMask;
  assign busy_o        = (state_q != IDLE);

endmodule
